// File: rtl/rs232_receive_pkg.sv
// Shared definitions for the RS-232 receiver: FSM state encoding and
// default bit timing (27 MHz clock, 19200 baud).
`timescale 1ns/1ps
package rs232_receive_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } rx_state_e;

  localparam int unsigned DEFAULT_CLKS_PER_BIT = 1406;
  localparam int unsigned DEFAULT_CNT_W        = 16;

endpackage

// File: rtl/rs232_bit_timer.sv
// Bit-timing counter for the RS-232 receiver.
// Counts clk cycles from the last clear and raises combinational
// terminal-count strobes at the half-bit and full-bit points.
// Ports:
//   clk     in  system clock
//   rst     in  synchronous reset, active low
//   clr_i   in  force counter to 0 on the next edge (else increment)
//   half_o  out counter == CLKS_PER_BIT/2 - 1
//   full_o  out counter == CLKS_PER_BIT - 1
`timescale 1ns/1ps
module rs232_bit_timer
  import rs232_receive_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned CNT_W        = DEFAULT_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic half_o,
  output logic full_o
);

  localparam logic [CNT_W-1:0] HALF_TC = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_TC = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // The owner clears at every sample point, so the counter never wraps.
  always_comb begin
    cnt_d = clr_i ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign half_o = (cnt_q == HALF_TC);
  assign full_o = (cnt_q == FULL_TC);

endmodule

// File: rtl/rs232_receive.sv
// RS-232 receiver, 8N1, LSB first, idle-high line.
// Synchronises the asynchronous line, detects the start edge, samples
// each bit at mid-bit and presents the byte through a valid/ack register.
// Ports:
//   clk          in   system clock
//   rst          in   synchronous reset, active low
//   rcv_data     in   serial line (asynchronous, idle 1)
//   data         out  last good byte; stable while data_valid=1
//   data_valid   out  holding register full, held until data_ack
//   data_ack     in   consumer acknowledge pulse
//   framing_err  out  one-cycle pulse when the stop bit samples 0
//   overrun      out  sticky: byte completed while data_valid=1
//   led_debug    out  1 while a frame is in progress
`timescale 1ns/1ps
module rs232_receive
  import rs232_receive_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned CNT_W        = DEFAULT_CNT_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rcv_data,
  output logic [7:0] data,
  output logic       data_valid,
  input  logic       data_ack,
  output logic       framing_err,
  output logic       overrun,
  output logic       led_debug
);

  rx_state_e  state_q;
  logic       rx_meta_q, rx_s_q, rx_d_q;
  logic [2:0] bit_idx_q;
  logic [7:0] shift_q;
  logic [7:0] data_q;
  logic       data_valid_q;
  logic       framing_err_q;
  logic       overrun_q;
  logic       fall;
  logic       timer_clr;
  logic       half_tc;
  logic       full_tc;

  // Two-flop synchroniser plus one delay stage for edge detection;
  // preset to 1 so reset looks like an idle line.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_d_q    <= 1'b1;
    end else begin
      rx_meta_q <= rcv_data;
      rx_s_q    <= rx_meta_q;
      rx_d_q    <= rx_s_q;
    end
  end

  assign fall = rx_d_q & ~rx_s_q;

  // Timer held at 0 outside a frame, restarted at every sample point.
  always_comb begin
    timer_clr = 1'b1;
    case (state_q)
      ST_START:         timer_clr = half_tc;
      ST_DATA, ST_STOP: timer_clr = full_tc;
      default:          timer_clr = 1'b1;
    endcase
  end

  rs232_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CNT_W        (CNT_W)
  ) u_bit_timer (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (timer_clr),
    .half_o (half_tc),
    .full_o (full_tc)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      bit_idx_q     <= '0;
      shift_q       <= '0;
      data_q        <= '0;
      data_valid_q  <= 1'b0;
      framing_err_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      framing_err_q <= 1'b0;

      // Ack is applied first so that a completion on the same edge
      // overrides the valid clear below.
      if (data_ack && data_valid_q) begin
        data_valid_q <= 1'b0;
        overrun_q    <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          if (fall) state_q <= ST_START;
        end
        ST_START: begin
          if (half_tc) begin
            if (!rx_s_q) begin
              state_q   <= ST_DATA;
              bit_idx_q <= '0;
            end else begin
              state_q   <= ST_IDLE;
            end
          end
        end
        ST_DATA: begin
          if (full_tc) begin
            shift_q   <= {rx_s_q, shift_q[7:1]};
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) state_q <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (full_tc) begin
            if (rx_s_q) begin
              data_q       <= shift_q;
              data_valid_q <= 1'b1;
              if (data_valid_q && !data_ack) overrun_q <= 1'b1;
              state_q      <= ST_IDLE;
            end else begin
              framing_err_q <= 1'b1;
              state_q       <= ST_WAIT_IDLE;
            end
          end
        end
        ST_WAIT_IDLE: begin
          if (rx_s_q) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign data        = data_q;
  assign data_valid  = data_valid_q;
  assign framing_err = framing_err_q;
  assign overrun     = overrun_q;
  assign led_debug   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rs232_receive.sv
`timescale 1ns/1ps
module tb_rs232_receive;

  localparam int unsigned CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rcv_data = 1'b1;
  logic       data_ack = 1'b0;
  logic [7:0] data;
  logic       data_valid, framing_err, overrun, led_debug;

  int n_checks = 0;
  int n_fail   = 0;
  int ferr_cnt = 0;
  int valid_rises = 0;
  logic [7:0] sb_q[$];
  logic prev_valid = 1'b0;
  logic prev_ovr   = 1'b0;

  always #5 clk = ~clk;

  rs232_receive #(
    .CLKS_PER_BIT (CPB),
    .CNT_W        (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rcv_data    (rcv_data),
    .data        (data),
    .data_valid  (data_valid),
    .data_ack    (data_ack),
    .framing_err (framing_err),
    .overrun     (overrun),
    .led_debug   (led_debug)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: a byte is delivered when data_valid rises, or when
  // overrun rises (new byte overwrote an unacknowledged one).
  always @(posedge clk) begin
    #2;
    if (framing_err) ferr_cnt++;
    if ((data_valid && !prev_valid) || (overrun && !prev_ovr)) begin
      valid_rises++;
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: got byte 0x%0h, expected none", data);
      end else begin
        check("sb_data", {24'h0, data}, {24'h0, sb_q.pop_front()});
      end
    end
    prev_valid = data_valid;
    prev_ovr   = overrun;
  end

  // Drives one frame starting at the current negedge. ack_at selects the
  // cycle index (posedge ack_at+1 samples it) for a data_ack pulse, -1 none.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int ack_at,
                            input bit chk_lat, input bit push);
    logic [9:0] bits;
    int k;
    bits = {stop, b, 1'b0};
    if (push && stop) sb_q.push_back(b);
    k = 0;
    for (int i = 0; i < 10; i++) begin
      rcv_data = bits[i];
      for (int c = 0; c < int'(CPB); c++) begin
        data_ack = (k == ack_at);
        @(negedge clk);
        k++;
        if (chk_lat && k == 154) check("latency_before", {31'h0, data_valid}, 32'h0);
        if (chk_lat && k == 155) check("latency_at", {31'h0, data_valid}, 32'h1);
      end
    end
    data_ack = 1'b0;
  endtask

  task automatic pulse_ack();
    data_ack = 1'b1;
    @(negedge clk);
    data_ack = 1'b0;
  endtask

  typedef struct {
    logic [7:0] b;
    int         ack_at;
    bit         lat;
    bit         exp_valid;
    logic [7:0] exp_data;
    bit         exp_ovr;
    bit         ack_after;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int f0;
    vecs[0] = '{8'h41, -1, 1'b1, 1'b1, 8'h41, 1'b0, 1'b1};
    vecs[1] = '{8'h55, -1, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0};
    vecs[2] = '{8'hAA,  0, 1'b0, 1'b1, 8'hAA, 1'b0, 1'b1};
    vecs[3] = '{8'h12, -1, 1'b0, 1'b1, 8'h12, 1'b0, 1'b0};
    vecs[4] = '{8'h34, -1, 1'b0, 1'b1, 8'h34, 1'b1, 1'b1};
    vecs[5] = '{8'h00, -1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1};
    vecs[6] = '{8'hFF, -1, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b1};

    // Reset state
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data", {24'h0, data}, 32'h0);
    check("rst_valid", {31'h0, data_valid}, 32'h0);
    check("rst_ferr", {31'h0, framing_err}, 32'h0);
    check("rst_ovr", {31'h0, overrun}, 32'h0);
    check("rst_led", {31'h0, led_debug}, 32'h0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // Table-driven good frames, including back-to-back and overrun
    for (int v = 0; v < 7; v++) begin
      f0 = ferr_cnt;
      send_frame(vecs[v].b, 1'b1, vecs[v].ack_at, vecs[v].lat, 1'b1);
      check($sformatf("v%0d_valid", v), {31'h0, data_valid}, {31'h0, vecs[v].exp_valid});
      check($sformatf("v%0d_data", v), {24'h0, data}, {24'h0, vecs[v].exp_data});
      check($sformatf("v%0d_ovr", v), {31'h0, overrun}, {31'h0, vecs[v].exp_ovr});
      check($sformatf("v%0d_ferr", v), ferr_cnt - f0, 32'h0);
      if (vecs[v].ack_after) begin
        pulse_ack();
        check($sformatf("v%0d_ack_valid", v), {31'h0, data_valid}, 32'h0);
        check($sformatf("v%0d_ack_ovr", v), {31'h0, overrun}, 32'h0);
      end
    end

    // Ack with nothing held has no effect
    pulse_ack();
    check("idle_ack_valid", {31'h0, data_valid}, 32'h0);

    // Short low glitch rejected at mid start bit
    f0 = ferr_cnt;
    rcv_data = 1'b0;
    repeat (4) @(negedge clk);
    rcv_data = 1'b1;
    check("glitch_led_busy", {31'h0, led_debug}, 32'h1);
    repeat (30) @(negedge clk);
    check("glitch_led_idle", {31'h0, led_debug}, 32'h0);
    check("glitch_valid", {31'h0, data_valid}, 32'h0);
    check("glitch_ferr", ferr_cnt - f0, 32'h0);

    // Stop bit 0 followed by a long break
    f0 = ferr_cnt;
    send_frame(8'h7E, 1'b0, -1, 1'b0, 1'b0);
    repeat (40) @(negedge clk);
    check("frm_ferr_pulses", ferr_cnt - f0, 32'h1);
    check("frm_valid", {31'h0, data_valid}, 32'h0);
    check("frm_led_wait", {31'h0, led_debug}, 32'h1);
    rcv_data = 1'b1;
    repeat (6) @(negedge clk);
    check("frm_led_idle", {31'h0, led_debug}, 32'h0);
    check("frm_ferr_total", ferr_cnt - f0, 32'h1);

    // Ack on the same edge as a completion while overrun is set
    send_frame(8'h21, 1'b1, -1, 1'b0, 1'b1);
    send_frame(8'h43, 1'b1, -1, 1'b0, 1'b1);
    check("ovr_set", {31'h0, overrun}, 32'h1);
    check("ovr_data", {24'h0, data}, 32'h43);
    send_frame(8'h65, 1'b1, 154, 1'b0, 1'b0);
    check("same_edge_valid", {31'h0, data_valid}, 32'h1);
    check("same_edge_data", {24'h0, data}, 32'h65);
    check("same_edge_ovr", {31'h0, overrun}, 32'h0);

    // Reset during DATA of 0xC3 (valid still held with 0x65)
    rcv_data = 1'b0;
    repeat (CPB) @(negedge clk);
    rcv_data = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    rcv_data = 1'b0;
    repeat (CPB) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_data", {24'h0, data}, 32'h0);
    check("midrst_valid", {31'h0, data_valid}, 32'h0);
    check("midrst_ovr", {31'h0, overrun}, 32'h0);
    check("midrst_led", {31'h0, led_debug}, 32'h0);
    rcv_data = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_valid", {31'h0, data_valid}, 32'h0);
    send_frame(8'h0F, 1'b1, -1, 1'b0, 1'b1);
    check("post_rst_data", {24'h0, data}, 32'h0F);
    check("post_rst_valid2", {31'h0, data_valid}, 32'h1);
    pulse_ack();
    check("post_rst_ack", {31'h0, data_valid}, 32'h0);

    repeat (5) @(negedge clk);
    check("sb_empty", sb_q.size(), 32'h0);
    check("delivery_count", valid_rises, 32'd10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
